// File: rtl/rs_pipeline_credit_ctrl_if.sv
// Write/read handshake bundle of the credit relay: upstream write port plus
// downstream FWFT pop port. The DUT uses the slave view.
interface rs_pipeline_credit_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic                  if_read;

    modport master (
        output if_din, if_write, if_read,
        input  if_full_n, if_dout, if_empty_n
    );

    modport slave (
        input  if_din, if_write, if_read,
        output if_full_n, if_dout, if_empty_n
    );
endinterface

// File: rtl/rs_pipeline_credit_ctrl.sv
// Credit-based relay: accepted writes cross LEVELS register stages into a FWFT buffer,
// and every pop returns one credit to the sender through a LEVELS-stage token path.
module rs_pipeline_credit_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LEVELS     = 2,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           ap_rst_n,
    rs_pipeline_credit_ctrl_if.slave       bus,
    output logic [$clog2(BUF_DEPTH+1)-1:0] credit_cnt
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic                  accept;
    logic                  pop;
    logic                  buf_wr;
    logic [DATA_WIDTH-1:0] buf_wdata;
    logic                  credit_ret;

    logic                  fwd_vld_p  [LEVELS];
    logic [DATA_WIDTH-1:0] fwd_data_p [LEVELS];
    logic                  ret_tok_p  [LEVELS];

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign bus.if_full_n  = (credit_cnt != '0);
    assign bus.if_empty_n = (occ != '0);
    assign bus.if_dout    = mem[rd_ptr];

    assign accept     = bus.if_write & bus.if_full_n;
    assign pop        = bus.if_read & bus.if_empty_n;
    assign buf_wr     = fwd_vld_p[LEVELS-1];
    assign buf_wdata  = fwd_data_p[LEVELS-1];
    assign credit_ret = ret_tok_p[LEVELS-1];

    // Forward relay: stage 0 captures the accepted word, later stages shift every cycle.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < LEVELS; i++) begin
                fwd_vld_p[i]  <= 1'b0;
                fwd_data_p[i] <= '0;
            end
        end else begin
            fwd_vld_p[0]  <= accept;
            fwd_data_p[0] <= bus.if_din;
            for (int i = 1; i < LEVELS; i++) begin
                fwd_vld_p[i]  <= fwd_vld_p[i-1];
                fwd_data_p[i] <= fwd_data_p[i-1];
            end
        end
    end

    // Return relay: one token per pop, delivered to the counter LEVELS cycles later.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < LEVELS; i++) begin
                ret_tok_p[i] <= 1'b0;
            end
        end else begin
            ret_tok_p[0] <= pop;
            for (int i = 1; i < LEVELS; i++) begin
                ret_tok_p[i] <= ret_tok_p[i-1];
            end
        end
    end

    // Simultaneous spend and return cancel out.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credit_cnt <= CNT_W'(BUF_DEPTH);
        end else if (accept && !credit_ret) begin
            credit_cnt <= credit_cnt - CNT_W'(1);
        end else if (!accept && credit_ret) begin
            credit_cnt <= credit_cnt + CNT_W'(1);
        end
    end

    // Receive buffer: a write only arrives against a spent credit, so it never overflows.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (buf_wr) begin
                mem[wr_ptr] <= buf_wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (buf_wr && !pop) begin
                occ <= occ + CNT_W'(1);
            end else if (!buf_wr && pop) begin
                occ <= occ - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rs_pipeline_credit_ctrl.sv
// Bench for rs_pipeline_credit_ctrl (LEVELS=2, BUF_DEPTH=8): directed scenarios plus
// random traffic, compared each cycle against a timestamp-based transaction model.
module tb_rs_pipeline_credit_ctrl;
    localparam int DW = 32;
    localparam int LV = 2;
    localparam int BD = 8;
    localparam int CW = $clog2(BD + 1);

    logic          clk = 1'b0;
    logic          ap_rst_n = 1'b1;
    logic [CW-1:0] credit_cnt;

    always #5 clk = ~clk;

    rs_pipeline_credit_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    rs_pipeline_credit_ctrl #(
        .DATA_WIDTH(DW),
        .LEVELS    (LV),
        .BUF_DEPTH (BD)
    ) dut (
        .clk       (clk),
        .ap_rst_n  (ap_rst_n),
        .bus       (bus),
        .credit_cnt(credit_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: a word accepted in cycle c is readable from cycle c+LV+1; a pop in
    // cycle c gives its credit back from cycle c+LV+1.
    int            cyc;
    int            m_credit;
    logic [DW-1:0] vis_q[$];
    logic [DW-1:0] pend_d[$];
    int            pend_t[$];
    int            ret_t[$];

    int            dut_acc;
    logic [DW-1:0] rx_q[$];
    int            first_pop;
    int            last_pop;
    int            min_credit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = BD;
        vis_q.delete();
        pend_d.delete();
        pend_t.delete();
        ret_t.delete();
        cyc = 0;
    endtask

    task automatic check_outputs();
        check("credit_cnt", 64'(credit_cnt), 64'(m_credit));
        check("if_full_n", 64'(bus.if_full_n), 64'(m_credit != 0));
        check("if_empty_n", 64'(bus.if_empty_n), 64'(vis_q.size() != 0));
        if (vis_q.size() != 0) begin
            check("if_dout", 64'(bus.if_dout), 64'(vis_q[0]));
        end
    endtask

    // One clock cycle: drive, compare, advance model, wait for the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        bit acc;
        bit pp;
        bus.if_write = w;
        bus.if_din   = d;
        bus.if_read  = r;
        #1;
        check_outputs();
        if (w && bus.if_full_n) dut_acc++;
        if (r && bus.if_empty_n) begin
            rx_q.push_back(bus.if_dout);
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (int'(credit_cnt) < min_credit) min_credit = int'(credit_cnt);
        acc = w && (m_credit != 0);
        pp  = r && (vis_q.size() != 0);
        if (acc) begin
            m_credit--;
            pend_d.push_back(d);
            pend_t.push_back(cyc + LV + 1);
        end
        if (pp) begin
            void'(vis_q.pop_front());
            ret_t.push_back(cyc + LV + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        while (pend_t.size() != 0 && pend_t[0] == cyc) begin
            vis_q.push_back(pend_d.pop_front());
            void'(pend_t.pop_front());
        end
        while (ret_t.size() != 0 && ret_t[0] == cyc) begin
            m_credit++;
            void'(ret_t.pop_front());
        end
    endtask

    // Reset takes effect at once, is held across one edge, then released mid-cycle.
    task automatic do_reset();
        ap_rst_n     = 1'b0;
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        bus.if_din   = '0;
        #1;
        check("rst_credit_cnt", 64'(credit_cnt), 64'(BD));
        check("rst_full_n", 64'(bus.if_full_n), 64'(1));
        check("rst_empty_n", 64'(bus.if_empty_n), 64'(0));
        check("rst_dout", 64'(bus.if_dout), 64'(0));
        @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        model_reset();
        dut_acc    = 0;
        first_pop  = -1;
        last_pop   = -1;
        min_credit = BD;
        rx_q.delete();
    endtask

    initial begin
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        bus.if_din   = '0;
        #2;
        do_reset();

        // Single write 0xA5 in cycle 10.
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'hA5, 1'b0);
        check("wr1_credit_c11", 64'(credit_cnt), 64'(7));
        step(1'b0, '0, 1'b0);
        check("wr1_empty_c12", 64'(bus.if_empty_n), 64'(0));
        step(1'b0, '0, 1'b0);
        check("wr1_empty_c13", 64'(bus.if_empty_n), 64'(1));
        check("wr1_dout_c13", 64'(bus.if_dout), 64'(32'hA5));

        // Fill: write held for 20 cycles, no reads.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i == 8) check("fill_full_n_c8", 64'(bus.if_full_n), 64'(0));
            step(1'b1, 32'h100 + 32'(i), 1'b0);
        end
        check("fill_accepts", 64'(dut_acc), 64'(8));
        check("fill_credit0", 64'(credit_cnt), 64'(0));

        // Single pop from full; credit comes back three cycles later.
        rx_q.delete();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("pop1_credit_m2", 64'(credit_cnt), 64'(0));
        step(1'b0, '0, 1'b0);
        check("pop1_credit_m3", 64'(credit_cnt), 64'(1));
        check("pop1_full_n_m3", 64'(bus.if_full_n), 64'(1));
        step(1'b1, 32'h1FF, 1'b0);
        check("pop1_rewrite_acc", 64'(dut_acc), 64'(9));
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
        check("drain_count", 64'(rx_q.size()), 64'(9));
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            check("drain_order", 64'(rx_q[i]), 64'((i < 8) ? (32'h100 + 32'(i)) : 32'h1FF));
        end

        // Streaming 0..99 with reads held high.
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 32'(i), 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        check("stream_count", 64'(rx_q.size()), 64'(100));
        for (int i = 0; i < 100 && i < rx_q.size(); i++) begin
            check("stream_data", 64'(rx_q[i]), 64'(i));
        end
        check("stream_first_pop", 64'(first_pop), 64'(3));
        check("stream_no_gaps", 64'(last_pop - first_pop), 64'(99));
        check("stream_min_credit_ge2", 64'(min_credit >= 2), 64'(1));

        // Random traffic in three write/read pressure mixes.
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            int wp;
            int rp;
            wp = (ph == 0) ? 85 : (ph == 1) ? 50 : 30;
            rp = (ph == 0) ? 25 : (ph == 1) ? 50 : 90;
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 99) < 32'(wp)) ? 1'b1 : 1'b0, $urandom(),
                     ($urandom_range(0, 99) < 32'(rp)) ? 1'b1 : 1'b0);
            end
        end

        // Reset mid-operation with 3 words buffered and 2 in flight.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
        check("midrst_pre_empty_n", 64'(bus.if_empty_n), 64'(1));
        check("midrst_pre_credit", 64'(credit_cnt), 64'(3));
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        check("midrst_no_stale", 64'(bus.if_empty_n), 64'(0));
        step(1'b1, 32'h3AA, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        check("midrst_new_word", 64'(bus.if_dout), 64'(32'h3AA));
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        check("midrst_credit_back", 64'(credit_cnt), 64'(BD));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rs_pipeline_credit_ctrl.md
RS_PIPELINE_CREDIT_CTRL -- requirements
Module: rs_pipeline_credit_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter LEVELS, default 2, number of forward FF relay stages (legal 1..8).
REQ-003 SHALL have parameter BUF_DEPTH, default 8, receive-buffer entries and initial credit count (legal 1..64).
REQ-004 SHALL have port clk  input  1  single clock for all state.
REQ-005 SHALL have port ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port if_din  input  DATA_WIDTH  upstream write data.
REQ-007 SHALL have port if_write  input  1  upstream write request.
REQ-008 SHALL have port if_full_n  output  1  upstream may write (credit available).
REQ-009 SHALL have port if_dout  output  DATA_WIDTH  head-of-buffer data.
REQ-010 SHALL have port if_empty_n  output  1  buffer holds valid data.
REQ-011 SHALL have port if_read  input  1  downstream pop request.
REQ-012 SHALL have port credit_cnt  output  clog2(BUF_DEPTH+1)  current available credits (status).

Function
REQ-013 SHALL accept a write in cycle n iff if_write=1 and if_full_n=1; if_write while if_full_n=0 SHALL be ignored.
REQ-014 SHALL set if_full_n = (credit_cnt != 0), combinationally from the registered counter.
REQ-015 SHALL carry accepted data through LEVELS non-stalling valid+data registers; data accepted in cycle n SHALL be written to the buffer at the end of cycle n+LEVELS.
REQ-016 SHALL make written data visible (if_empty_n=1, if_dout valid) in cycle n+LEVELS+1.
REQ-017 SHALL implement the buffer as a FIFO of BUF_DEPTH entries with wrapping read/write pointers, first-word-fall-through on if_dout.
REQ-018 SHALL pop in cycle m iff if_read=1 and if_empty_n=1; if_read while empty SHALL be ignored.
REQ-019 SHALL return each pop as a credit token through LEVELS return-path registers; a pop in cycle m SHALL increment the counter at the end of cycle m+LEVELS.
REQ-020 SHALL update credit_cnt each edge as credit_cnt - accept + returned; simultaneous accept and return SHALL leave it unchanged.
REQ-021 SHALL guarantee the invariant credit_cnt + in-flight forward + buffer occupancy + in-flight return tokens = BUF_DEPTH; buffer overflow SHALL be impossible.
REQ-022 SHALL support simultaneous buffer write and pop in one cycle, including when buffer is full or holds one entry.
REQ-023 SHALL sustain one transfer per cycle when BUF_DEPTH >= 2*LEVELS+2 and if_read is held 1.
REQ-024 SHALL never let credit_cnt exceed BUF_DEPTH or underflow below 0.

Reset
REQ-025 SHALL, while ap_rst_n=0, immediately force credit_cnt=BUF_DEPTH, if_full_n=1, if_empty_n=0, all forward valid bits and return tokens 0, FIFO pointers 0.
REQ-026 SHALL reset if_dout and all pipeline data registers to 0.
REQ-027 SHALL discard in-flight data and tokens on reset mid-operation; first post-reset cycle behaves as after power-on.

Verification (LEVELS=2, BUF_DEPTH=8)
REQ-028 SHALL cover: release reset -> credit_cnt=8, if_full_n=1, if_empty_n=0, if_dout=0.
REQ-029 SHALL cover: single write 0xA5 in cycle 10, no reads -> if_empty_n=1 and if_dout=0xA5 first in cycle 13; credit_cnt=7 from cycle 11.
REQ-030 SHALL cover: if_write held 1, if_read 0 for 20 cycles -> exactly 8 accepted, if_full_n=0 from cycle after 8th accept, buffer holds all 8 in order.
REQ-031 SHALL cover: from full state, single pop in cycle m -> credit_cnt=1 and if_full_n=1 in cycle m+3, next write accepted.
REQ-032 SHALL cover: continuous write and read of incrementing values 0..99 -> 100 values out in order, no gaps after initial 3-cycle latency, credit_cnt never below 2.
REQ-033 SHALL cover: ap_rst_n pulsed low for 1 cycle with 2 words in flight and 3 buffered -> outputs return to reset values immediately, no stale word emerges afterward.
